// File: rtl/bpred_pkg.sv
// Shared types and constants for the gshare + RAS branch predictor.
package bpred_pkg;

  // Branch type encodings as carried on upd_br_type and stored per BTB entry.
  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JUMP = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_type_e;

  // 2-bit saturating counter states.
  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  // Widest possible tag (BTB_IDX_W >= 0); narrower tags are zero-extended.
  localparam int unsigned TAG_MAX_W = 30;

  typedef struct packed {
    logic [TAG_MAX_W-1:0] tag;
    br_type_e             br_type;
    logic [31:0]          target;
  } btb_entry_t;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bpred_ras.sv
// Circular return address stack. Push when full overwrites the oldest entry;
// pop when empty is ignored. DEPTH must be a power of 2, at least 2.
module bpred_ras #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        empty
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

  logic [31:0]     mem_q [DEPTH];
  logic [PtrW-1:0] ptr_q;  // next free slot
  logic [PtrW:0]   cnt_q;

  assign empty = (cnt_q == '0);
  assign top   = mem_q[ptr_q - PtrW'(1)];

  // Pointer and occupancy; push takes priority over pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_q + PtrW'(1);
      if (cnt_q != Full) cnt_q <= cnt_q + (PtrW + 1)'(1);
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - PtrW'(1);
      cnt_q <= cnt_q - (PtrW + 1)'(1);
    end
  end

  // Stack storage; contents are only observed while non-empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/bpred_gshare_ras.sv
// IF-stage branch predictor: direct-mapped BTB, gshare PHT, optional RAS.
// Define BPRED_RAS_EN to compile in the return address stack.
module bpred_gshare_ras
  import bpred_pkg::*;
#(
  parameter int unsigned BTB_IDX_W = 8,
  parameter int unsigned PHT_IDX_W = 10,
  parameter int unsigned GHR_W     = 8,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      pc,
  input  logic             fetch_valid,
  output logic [31:0]      pred_next_pc,
  output logic             pred_br_taken,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_en,
  input  logic [31:0]      upd_inst_addr,
  input  logic             upd_br_inst,
  input  logic [1:0]       upd_br_type,
  input  logic             upd_br_taken,
  input  logic [31:0]      upd_br_target,
  input  logic             upd_pred_taken,
  input  logic [GHR_W-1:0] upd_ghr,
  output logic [31:0]      branch_total_count,
  output logic [31:0]      branch_correct_count
);
  localparam int unsigned BtbEntries = 1 << BTB_IDX_W;
  localparam int unsigned PhtEntries = 1 << PHT_IDX_W;

  // History is aligned to the MSB end of the PHT index.
  function automatic logic [PHT_IDX_W-1:0] hist_ext(input logic [GHR_W-1:0] h);
    return PHT_IDX_W'(h) << (PHT_IDX_W - GHR_W);
  endfunction

  logic [BtbEntries-1:0] btb_valid_q;
  btb_entry_t            btb_q [BtbEntries];
  logic [1:0]            pht_q [PhtEntries];
  logic [GHR_W-1:0]      ghr_q;
  logic [31:0]           total_q, correct_q;

  // Fetch-side lookup.
  logic [BTB_IDX_W-1:0] f_idx;
  logic [TAG_MAX_W-1:0] f_tag;
  btb_entry_t           f_ent;
  logic                 btb_hit;
  logic [PHT_IDX_W-1:0] f_pht_idx;
  logic [31:0]          pc_plus4;
  logic                 ras_empty;
  logic [31:0]          ras_top;

  assign f_idx     = pc[BTB_IDX_W+1:2];
  assign f_tag     = TAG_MAX_W'(pc[31:BTB_IDX_W+2]);
  assign f_ent     = btb_q[f_idx];
  assign btb_hit   = btb_valid_q[f_idx] && (f_ent.tag == f_tag);
  assign f_pht_idx = pc[PHT_IDX_W+1:2] ^ hist_ext(ghr_q);
  assign pc_plus4  = pc + 32'd4;

  // Update-side decode.
  logic                 upd_fire, upd_cond;
  logic [BTB_IDX_W-1:0] u_idx;
  logic [PHT_IDX_W-1:0] u_pht_idx;
  logic [1:0]           unused_upd_addr;

  assign upd_fire        = upd_en && upd_br_inst;
  assign upd_cond        = upd_fire && (upd_br_type == BR_COND);
  assign u_idx           = upd_inst_addr[BTB_IDX_W+1:2];
  assign u_pht_idx       = upd_inst_addr[PHT_IDX_W+1:2] ^ hist_ext(upd_ghr);
  assign unused_upd_addr = upd_inst_addr[1:0];

`ifdef BPRED_RAS_EN
  logic ras_push, ras_pop;
  assign ras_push = fetch_valid && btb_hit && (f_ent.br_type == BR_CALL);
  assign ras_pop  = fetch_valid && btb_hit && (f_ent.br_type == BR_RET);

  bpred_ras #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .resetn   (resetn),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(pc_plus4),
    .top      (ras_top),
    .empty    (ras_empty)
  );
`else
  logic unused_fetch_valid;
  assign unused_fetch_valid = fetch_valid;
  assign ras_empty          = 1'b1;
  assign ras_top            = '0;
`endif

  // Combinational prediction from the current pc and table state.
  always_comb begin
    pred_br_taken = 1'b0;
    pred_next_pc  = pc_plus4;
    if (btb_hit) begin
      unique case (f_ent.br_type)
        BR_COND: begin
          if (pht_q[f_pht_idx][1]) begin
            pred_br_taken = 1'b1;
            pred_next_pc  = f_ent.target;
          end
        end
        BR_JUMP, BR_CALL: begin
          pred_br_taken = 1'b1;
          pred_next_pc  = f_ent.target;
        end
        BR_RET: begin
          pred_br_taken = 1'b1;
          pred_next_pc  = ras_empty ? f_ent.target : ras_top;
        end
      endcase
    end
  end

  assign pred_ghr             = ghr_q;
  assign branch_total_count   = total_q;
  assign branch_correct_count = correct_q;

  // BTB valid bits; an entry becomes valid on any branch update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btb_valid_q <= '0;
    end else if (upd_fire) begin
      btb_valid_q[u_idx] <= 1'b1;
    end
  end

  // BTB payload; gated by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (upd_fire) begin
      btb_q[u_idx] <= '{tag:     TAG_MAX_W'(upd_inst_addr[31:BTB_IDX_W+2]),
                        br_type: br_type_e'(upd_br_type),
                        target:  upd_br_target};
    end
  end

  // PHT counters, GHR and statistics advance only on conditional branches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(PhtEntries); i++) pht_q[i] <= CTR_WNT;
      ghr_q     <= '0;
      total_q   <= '0;
      correct_q <= '0;
    end else if (upd_cond) begin
      pht_q[u_pht_idx] <= ctr_update(pht_q[u_pht_idx], upd_br_taken);
      // Built from the snapshot so back-to-back updates see a consistent history.
      ghr_q            <= GHR_W'({upd_ghr, upd_br_taken});
      total_q          <= total_q + 32'd1;
      if (upd_pred_taken == upd_br_taken) correct_q <= correct_q + 32'd1;
    end
  end

endmodule
